// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and default parameters for the FIFO read-side arbiter.
package fifo_rd_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   localparam int DEF_DSIZE     = 8;
   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Bus between the FIFO read port, the consumers and the read arbiter.
// The master modport is the arbiter's view of the bus.
interface fifo_rd_arbiter_if
   import fifo_rd_arb_pkg::*;
#(
   parameter int DSIZE   = DEF_DSIZE,
   parameter int NUM_REQ = DEF_NUM_REQ
);
   localparam int IW = $clog2(NUM_REQ);

   logic               rempty;
   logic [DSIZE-1:0]   rdata;
   logic               rinc;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] ready;
   logic [NUM_REQ-1:0] gnt;
   logic               dout_valid;
   logic [DSIZE-1:0]   dout;
   logic [IW-1:0]      dout_id;
   logic               burst_done;

   modport master (
      input  rempty, rdata, req, ready,
      output rinc, gnt, dout_valid, dout, dout_id, burst_done
   );

   modport slave (
      output rempty, rdata, req, ready,
      input  rinc, gnt, dout_valid, dout, dout_id, burst_done
   );
endinterface

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: searches upward from the index after
// last_winner, wrapping, and returns the first requester as one-hot and index.
module fifo_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      last_winner,
   output logic [NUM_REQ-1:0] pick_oh,
   output logic [IW-1:0]      pick_idx
);

   int          pos;
   logic [IW-1:0] pos_i;
   logic        found;

   // Priority scan starting one past the previous winner.
   always_comb begin
      pos      = 0;
      pos_i    = '0;
      found    = 1'b0;
      pick_oh  = '0;
      pick_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         pos   = (int'(last_winner) + i) % NUM_REQ;
         pos_i = IW'(pos);
         if (!found && req[pos_i]) begin
            found          = 1'b1;
            pick_oh[pos_i] = 1'b1;
            pick_idx       = pos_i;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter: grants the FIFO read port to one consumer at a time for
// up to MAX_BURST pops and delivers popped words one cycle later.
// Optional: define FIFO_RD_ARB_STATS_EN to add the 16-bit wrapping pop_cnt output.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no grant; arbitrate when the FIFO has data and anyone requests
//   ST_BURST | gnt held; pop whenever FIFO non-empty and consumer req & ready
module fifo_rd_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter int DSIZE     = DEF_DSIZE,
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                   rclk,
   input  logic                   rrst_n,
   fifo_rd_arbiter_if.master      bus
`ifdef FIFO_RD_ARB_STATS_EN
   ,
   output logic [15:0]            pop_cnt
`endif
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
   logic [IW-1:0]      gidx, gidx_nxt;
   logic [IW-1:0]      last_winner, lw_nxt;
   logic [BW-1:0]      burst_cnt, cnt_nxt;
   logic               done_q, done_nxt;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IW-1:0]      pick_idx;
   logic               req_g, rdy_g, pop, last_pop;
   logic               dv_q;
   logic [DSIZE-1:0]   dout_q;
   logic [IW-1:0]      id_q;

   fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req         (bus.req),
      .last_winner (last_winner),
      .pick_oh     (pick_oh),
      .pick_idx    (pick_idx)
   );

   assign req_g    = bus.req[gidx];
   assign rdy_g    = bus.ready[gidx];
   assign pop      = (state == ST_BURST) & ~bus.rempty & req_g & rdy_g;
   assign last_pop = pop && (burst_cnt == BW'(MAX_BURST - 1));

   assign bus.rinc       = pop;
   assign bus.gnt        = gnt_q;
   assign bus.burst_done = done_q;
   assign bus.dout_valid = dv_q;
   assign bus.dout       = dout_q;
   assign bus.dout_id    = id_q;

   // FSM state and grant bookkeeping registers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state       <= ST_IDLE;
         gnt_q       <= '0;
         gidx        <= '0;
         last_winner <= IW'(NUM_REQ - 1);
         burst_cnt   <= '0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         gnt_q       <= gnt_nxt;
         gidx        <= gidx_nxt;
         last_winner <= lw_nxt;
         burst_cnt   <= cnt_nxt;
         done_q      <= done_nxt;
      end
   end

   // Next-state: arbitrate only from IDLE, so an exit cycle never re-grants.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_q;
      gidx_nxt  = gidx;
      lw_nxt    = last_winner;
      cnt_nxt   = burst_cnt;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!bus.rempty && (|bus.req)) begin
               state_nxt = ST_BURST;
               gnt_nxt   = pick_oh;
               gidx_nxt  = pick_idx;
               lw_nxt    = pick_idx;
               cnt_nxt   = '0;
            end
         end
         ST_BURST: begin
            if (pop) cnt_nxt = burst_cnt + BW'(1);
            // A pop coinciding with req drop still completes; exit same cycle.
            if (last_pop || !req_g) begin
               state_nxt = ST_IDLE;
               gnt_nxt   = '0;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Delivery stage: popped head word appears one cycle after the pop.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         dv_q   <= 1'b0;
         dout_q <= '0;
         id_q   <= '0;
      end else begin
         dv_q <= pop;
         if (pop) begin
            dout_q <= bus.rdata;
            id_q   <= gidx;
         end
      end
   end

`ifdef FIFO_RD_ARB_STATS_EN
   // Free-running pop counter, wraps naturally at 16 bits.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)  pop_cnt <= '0;
      else if (pop) pop_cnt <= pop_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural grant/delivery model.
module tb_fifo_rd_arbiter;

   localparam int N  = 4;
   localparam int MB = 4;
   localparam int DW = 8;

   logic rclk   = 1'b0;
   logic rrst_n = 1'b1;
   always #5 rclk = ~rclk;

   fifo_rd_arbiter_if #(.DSIZE(DW), .NUM_REQ(N)) bus ();
`ifdef FIFO_RD_ARB_STATS_EN
   logic [15:0] pop_cnt;
`endif

   fifo_rd_arbiter #(.DSIZE(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .bus    (bus)
`ifdef FIFO_RD_ARB_STATS_EN
      ,
      .pop_cnt(pop_cnt)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   // environment: FIFO contents and per-cycle stimulus
   logic [DW-1:0] fifo_q[$];
   int            wr_pend = 0;
   logic [DW-1:0] wr_data = 8'h10;
   logic [N-1:0]  req_s = '0;
   logic [N-1:0]  rdy_s = '0;
   logic          rinc_seen = 1'b0;

   // reference model: who owns the port, pops in this grant, delivery stage
   int            m_owner;
   int            m_pops;
   int            m_lw;
   bit            m_dv;
   logic [DW-1:0] m_dout;
   int            m_did;
   bit            m_done;

   // observation logs taken from the DUT
   int obs_pops, obs_dv, obs_done, zero_run;
   int grant_log[$];
   int pop_log[$];
   int gap_log[$];
   logic [N-1:0] prev_gnt;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic int oh2idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_pops = 0; m_lw = N - 1;
      m_dv = 0; m_dout = '0; m_did = 0; m_done = 0;
   endtask

   task automatic clr_logs();
      obs_pops = 0; obs_dv = 0; obs_done = 0; zero_run = 0; prev_gnt = '0;
      grant_log.delete(); pop_log.delete(); gap_log.delete();
   endtask

   task automatic drive();
      bus.rempty = (fifo_q.size() == 0);
      bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      bus.req    = req_s;
      bus.ready  = rdy_s;
   endtask

   task automatic check_cycle();
      bit e_rinc;
      bit m_empty;
      int c;
      m_empty = (fifo_q.size() == 0);
      e_rinc  = (m_owner >= 0) && !m_empty && req_s[m_owner] && rdy_s[m_owner];
      chk("gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("rinc", 32'(bus.rinc), 32'(e_rinc));
      chk("dout_valid", 32'(bus.dout_valid), 32'(m_dv));
      if (m_dv) begin
         chk("dout", 32'(bus.dout), 32'(m_dout));
         chk("dout_id", 32'(bus.dout_id), 32'(m_did));
      end
      chk("burst_done", 32'(bus.burst_done), 32'(m_done));

      if (bus.rinc) obs_pops++;
      if (bus.dout_valid) obs_dv++;
      if (bus.burst_done) obs_done++;
      if (bus.gnt != 0 && prev_gnt == 0) begin
         if (grant_log.size() > 0) gap_log.push_back(zero_run);
         grant_log.push_back(oh2idx(bus.gnt));
         pop_log.push_back(0);
      end
      if (bus.gnt != 0 && bus.rinc && pop_log.size() > 0)
         pop_log[pop_log.size()-1]++;
      if (bus.gnt == 0) zero_run++; else zero_run = 0;
      prev_gnt = bus.gnt;

      // advance model by one clock
      m_dv   = e_rinc;
      if (e_rinc) begin
         m_dout = fifo_q[0];
         m_did  = m_owner;
      end
      m_done = 0;
      if (m_owner >= 0) begin
         if (e_rinc) m_pops++;
         if ((e_rinc && m_pops == MB) || !req_s[m_owner]) begin
            m_owner = -1;
            m_done  = 1;
         end
      end else if (!m_empty && req_s != 0) begin
         for (int k = 1; k <= N; k++) begin
            c = (m_lw + k) % N;
            if (req_s[c]) begin
               m_owner = c;
               break;
            end
         end
         m_lw   = m_owner;
         m_pops = 0;
      end
   endtask

   task automatic step();
      @(posedge rclk);
      #1;
      if (rinc_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      repeat (wr_pend) begin
         fifo_q.push_back(wr_data);
         wr_data = wr_data + 8'd1;
      end
      wr_pend = 0;
      drive();
      @(negedge rclk);
      check_cycle();
      rinc_seen = bus.rinc;
   endtask

   task automatic do_reset(input bit keep_fifo);
      if (!keep_fifo) fifo_q.delete();
      req_s = '0;
      rdy_s = '0;
      wr_pend = 0;
      drive();
      rrst_n = 1'b0;
      #1;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_dout_id", 32'(bus.dout_id), 32'd0);
      chk("rst_burst_done", 32'(bus.burst_done), 32'd0);
      model_reset();
      repeat (2) @(posedge rclk);
      @(negedge rclk);
      rrst_n    = 1'b1;
      rinc_seen = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cap;
      int hold;
      int exp_g[3] = '{0, 1, 2};
      int exp_p[3] = '{4, 4, 2};
      model_reset();
      clr_logs();
      #2;

      // single consumer, 3 words, release on req drop
      do_reset(0); clr_logs();
      wr_pend = 3; req_s = 4'b0001; rdy_s = 4'b0001;
      for (cap = 0; cap < 20 && obs_pops < 3; cap++) step();
      chk("t1_pops", 32'(obs_pops), 32'd3);
      step();
      req_s = '0;
      repeat (3) step();
      chk("t1_deliveries", 32'(obs_dv), 32'd3);
      chk("t1_burst_done", 32'(obs_done), 32'd1);
      chk("t1_first_winner", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);

      // four consumers, 10 words, bursts of 4
      do_reset(0); clr_logs();
      wr_pend = 10; req_s = 4'b1111; rdy_s = 4'b1111;
      repeat (20) step();
      req_s = '0;
      repeat (3) step();
      chk("t2_grants", 32'(grant_log.size()), 32'd3);
      chk("t2_gaps", 32'(gap_log.size()), 32'd2);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t2_order%0d", i), (i < grant_log.size()) ? grant_log[i] : -1, exp_g[i]);
         chk($sformatf("t2_pops%0d", i), (i < pop_log.size()) ? pop_log[i] : -1, exp_p[i]);
      end
      for (int i = 0; i < 2; i++)
         chk($sformatf("t2_gap%0d", i), (i < gap_log.size()) ? gap_log[i] : -1, 32'd1);

      // consumer 2 stalls on ready, then resumes
      do_reset(0); clr_logs();
      wr_pend = 6; req_s = 4'b0100; rdy_s = 4'b0000;
      step();
      hold = 0;
      repeat (5) begin
         step();
         if (bus.gnt == 4'b0100 && !bus.rinc) hold++;
      end
      chk("t3_hold_cycles", 32'(hold), 32'd5);
      chk("t3_no_pop", 32'(obs_pops), 32'd0);
      rdy_s = 4'b0100;
      step();
      chk("t3_resume", 32'(bus.rinc), 32'd1);
      repeat (6) step();
      req_s = '0;
      repeat (3) step();
      chk("t3_total_pops", 32'(obs_pops), 32'd6);

      // FIFO runs dry mid-burst, then refills
      do_reset(0); clr_logs();
      wr_pend = 2; req_s = 4'b0001; rdy_s = 4'b0001;
      repeat (6) step();
      chk("t4_gnt_held", 32'(bus.gnt), 32'd1);
      chk("t4_no_pop_empty", 32'(bus.rinc), 32'd0);
      wr_pend = 1;
      step();
      chk("t4_pop_on_refill", 32'(bus.rinc), 32'd1);
      step();
      req_s = '0;
      repeat (3) step();
      chk("t4_total_pops", 32'(obs_pops), 32'd3);

      // reset after 2 of 4 pops
      do_reset(0); clr_logs();
      wr_pend = 4; req_s = 4'b0001; rdy_s = 4'b0001;
      for (cap = 0; cap < 20 && obs_pops < 2; cap++) step();
      rdy_s = '0;
      step();
      chk("t5_dv_before_rst", 32'(bus.dout_valid), 32'd1);
      do_reset(1);
      chk("t5_words_left", 32'(fifo_q.size()), 32'd2);
      clr_logs();
      req_s = 4'b0001; rdy_s = 4'b0001;
      repeat (6) step();
      chk("t5_deliveries_after", 32'(obs_dv), 32'd2);
      chk("t5_fifo_drained", 32'(fifo_q.size()), 32'd0);

      // random traffic with occasional async resets
      do_reset(0); clr_logs();
      repeat (3000) begin
         req_s = N'($urandom);
         rdy_s = N'($urandom) | N'($urandom);
         if (fifo_q.size() < 12 && $urandom_range(0, 2) != 0) wr_pend = $urandom_range(1, 2);
         step();
         if ($urandom_range(0, 499) == 0) do_reset(1);
      end

`ifdef FIFO_RD_ARB_STATS_EN
      // pop counter wraps after 65536 pops
      do_reset(0); clr_logs();
      chk("stats_rst", 32'(pop_cnt), 32'd0);
      req_s = 4'b0001; rdy_s = 4'b0001;
      for (cap = 0; cap < 95000 && obs_pops < 65537; cap++) begin
         if (fifo_q.size() < 4) wr_pend = 1;
         step();
      end
      chk("stats_pops_done", 32'(obs_pops), 32'd65537);
      rdy_s = '0;
      step();
      chk("stats_pop_cnt_wrap", 32'(pop_cnt), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 SHALL have parameter DSIZE, default 8, read-data width.
REQ-002 SHALL have parameter NUM_REQ, default 4, consumer count, legal range 2..16.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum pops per grant, legal value 1 or greater.
REQ-004 SHALL have port: rclk  in  1  read-domain clock.
REQ-005 SHALL have port: rrst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: rempty  in  1  FIFO empty flag, registered, from the read-pointer logic.
REQ-007 SHALL have port: rdata  in  DSIZE  FIFO head word, valid whenever rempty=0.
REQ-008 SHALL have port: rinc  out  1  FIFO pop strobe.
REQ-009 SHALL have port: req  in  NUM_REQ  per-consumer request, level.
REQ-010 SHALL have port: ready  in  NUM_REQ  per-consumer accept-next-cycle.
REQ-011 SHALL have port: gnt  out  NUM_REQ  one-hot grant, registered.
REQ-012 SHALL have port: dout_valid  out  1  delivered-word strobe.
REQ-013 SHALL have port: dout  out  DSIZE  delivered word.
REQ-014 SHALL have port: dout_id  out  $clog2(NUM_REQ)  index of the destination consumer.
REQ-015 SHALL have port: burst_done  out  1  one-cycle pulse on grant release.

Function
REQ-016 SHALL implement FSM states IDLE and BURST, encoded in a package enum.
REQ-017 In IDLE with rempty=0 and any req bit set, SHALL pick a winner round-robin, starting at the index after last_winner, register gnt, load last_winner, clear burst_cnt, and go to BURST.
REQ-018 In IDLE with rempty=1, SHALL hold gnt=0 regardless of req.
REQ-019 SHALL drive rinc combinationally as (state==BURST) & ~rempty & req[g] & ready[g], where g is the granted index.
REQ-020 On each rinc, SHALL register dout<=rdata, dout_id<=g, and dout_valid<=1 in the next cycle; dout_valid SHALL be 0 otherwise, giving a fixed latency of 1 cycle from pop to delivery.
REQ-021 burst_cnt width SHALL be $clog2(MAX_BURST+1) bits, and burst_cnt SHALL increment on each rinc.
REQ-022 SHALL leave BURST for IDLE, clear gnt, and pulse burst_done when rinc occurs with burst_cnt==MAX_BURST-1, or when req[g]=0.
REQ-023 If a pop and a req[g] drop coincide, the pop SHALL complete and the exit SHALL occur in the same cycle.
REQ-024 While in BURST with rempty=1 or ready[g]=0 and req[g]=1, SHALL hold the grant with no pop and no timeout.
REQ-025 SHALL not re-arbitrate in the cycle of exit; the minimum gap between grants SHALL be 1 IDLE cycle.
REQ-026 gnt SHALL never have more than 1 bit set, and rinc SHALL never assert while rempty=1.

Reset
REQ-027 On rrst_n low, SHALL set state=IDLE, gnt=0, dout_valid=0, dout=0, dout_id=0, burst_done=0, burst_cnt=0, and last_winner=NUM_REQ-1, so that consumer 0 wins first.
REQ-028 Reset mid-burst SHALL abort the grant; unpopped words SHALL remain in the FIFO, and no dout_valid SHALL follow reset release.

Configuration
REQ-029 With FIFO_RD_ARB_STATS_EN defined, SHALL add output pop_cnt [15:0], reset to 0, incremented on every rinc, wrapping 0xFFFF to 0.
REQ-030 Without FIFO_RD_ARB_STATS_EN, the pop_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package fifo_rd_arb_pkg SHALL hold the state enum type and a default-parameter constants block.
REQ-032 Round-robin selection SHALL be a separate combinational sub-module, fifo_rr_pick, with inputs req and last_winner and outputs a one-hot result and an index.

Verification
REQ-033 Bench SHALL check: after reset, FIFO holds 3 words, req=0001, ready=0001 -> gnt=0001, 3 rinc pulses, dout_valid for 3 cycles with dout_id=0, burst_done when req drops.
REQ-034 Bench SHALL check: FIFO holds 10 words, req=1111, ready=1111, MAX_BURST=4 -> grant order 0,1,2 with 4,4,2 pops and a 1-cycle IDLE gap between grants.
REQ-035 Bench SHALL check: granted consumer 2 with ready[2]=0 for 5 cycles -> rinc=0 and gnt held; ready[2]=1 -> pops resume.
REQ-036 Bench SHALL check: FIFO runs empty mid-burst with req held -> rinc=0 and gnt held; a new write arrives -> pop within 1 cycle of rempty falling.
REQ-037 Bench SHALL check: rrst_n asserted after 2 of 4 pops -> gnt=0 and dout_valid=0 immediately, and the remaining words stay readable.
REQ-038 Bench SHALL check, with FIFO_RD_ARB_STATS_EN defined: 65537 pops -> pop_cnt=1.
